// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the N-approach intersection controller.
//   - lamp codes driven on each road's 2-bit light field
//   - phase enumeration for the controller FSM
//   - rr_next(): wrap-around "first requester after cur" search
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;

  localparam int MAX_ROADS = 16;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  // Returns the first set bit of req strictly after cur, wrapping modulo n.
  // When nothing is set the result is cur; callers qualify with |req.
  function automatic logic [3:0] rr_next(input logic [15:0] req,
                                         input logic [3:0]  cur,
                                         input int          n);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = cur;
    found = 1'b0;
    for (int k = 1; k <= MAX_ROADS; k++) begin
      // cur < n and k <= n, so one conditional subtract replaces a modulo.
      idx = int'(cur) + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !found && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// rr_pick: purely combinational round-robin search over N_ROADS requesters.
// Ports:
//   req_i   [N_ROADS-1:0]  request vector
//   cur_i   [W-1:0]        current owner; search starts at cur_i+1
//   pick_o  [W-1:0]        first requester after cur_i (wrapping)
//   valid_o                any request present
module rr_pick
  import traffic_pkg::*;
#(
  parameter int  N_ROADS = 4,
  localparam int W       = $clog2(N_ROADS)
) (
  input  logic [N_ROADS-1:0] req_i,
  input  logic [W-1:0]       cur_i,
  output logic [W-1:0]       pick_o,
  output logic               valid_o
);

  logic [15:0] req_ext;
  logic [3:0]  cur_ext;
  logic [3:0]  pick_ext;

  assign req_ext  = 16'(req_i);
  assign cur_ext  = 4'(cur_i);
  assign pick_ext = rr_next(req_ext, cur_ext, N_ROADS);
  assign pick_o   = W'(pick_ext);
  assign valid_o  = |req_i;

endmodule

// File: rtl/traffic_rr_ctrl.sv
// traffic_rr_ctrl: N-approach intersection light controller with round-robin
// service, gap-out/max-out green termination, all-red clearance and
// emergency preemption. Phase timer is internal.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   car_req       per-road car present (synchronised level)
//   emg_req       emergency preemption request (level)
//   emg_road      road requested by the emergency
//   lights        per-road lamp code, road i at [2i+1:2i]
//   cur_road      road owning green/yellow
//   green_start   one-cycle pulse on the first cycle of each green
//   phase         current phase code (phase_e)
module traffic_rr_ctrl
  import traffic_pkg::*;
#(
  parameter int  N_ROADS    = 4,
  parameter int  MIN_GREEN  = 4,
  parameter int  MAX_GREEN  = 10,
  parameter int  YELLOW_CYC = 2,
  parameter int  ALLRED_CYC = 1,
  parameter int  HOME_ROAD  = 0,
  localparam int RW         = $clog2(N_ROADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_ROADS-1:0]     car_req,
  input  logic                   emg_req,
  input  logic [RW-1:0]          emg_road,
  output logic [2*N_ROADS-1:0]   lights,
  output logic [RW-1:0]          cur_road,
  output logic                   green_start,
  output logic [1:0]             phase
);

  localparam int T_MAX0 = (MAX_GREEN > YELLOW_CYC) ? MAX_GREEN : YELLOW_CYC;
  localparam int T_MAX  = (T_MAX0 > ALLRED_CYC) ? T_MAX0 : ALLRED_CYC;
  localparam int TW     = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] MIN_TH = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_TH = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_TH = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] AR_TH  = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] T_SAT  = '1;

  if (MIN_GREEN > MAX_GREEN) begin : g_err_min_max
    $error("traffic_rr_ctrl: MIN_GREEN must not exceed MAX_GREEN");
  end
  if (MIN_GREEN < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1) begin : g_err_len
    $error("traffic_rr_ctrl: phase lengths must be at least 1");
  end
  if (HOME_ROAD < 0 || HOME_ROAD >= N_ROADS) begin : g_err_home
    $error("traffic_rr_ctrl: HOME_ROAD out of range");
  end
  if (N_ROADS < 2 || N_ROADS > MAX_ROADS) begin : g_err_roads
    $error("traffic_rr_ctrl: N_ROADS must be 2..16");
  end

  phase_e        phase_q, phase_d;
  logic [RW-1:0] cur_road_q, cur_road_d;
  logic [RW-1:0] next_road_q, next_road_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          green_start_q, green_start_d;

  logic [N_ROADS-1:0] other;
  logic [RW-1:0]      pick_road;
  logic               pick_valid;
  logic               emg_away, emg_here, gap_out, max_out, leave_green;

  assign other = car_req & ~(N_ROADS'(1) << cur_road_q);

  rr_pick #(.N_ROADS(N_ROADS)) u_pick (
    .req_i   (other),
    .cur_i   (cur_road_q),
    .pick_o  (pick_road),
    .valid_o (pick_valid)
  );

  assign emg_away    = emg_req && (emg_road != cur_road_q);
  assign emg_here    = emg_req && (emg_road == cur_road_q);
  assign gap_out     = pick_valid && (timer_q >= MIN_TH) && !car_req[cur_road_q];
  assign max_out     = pick_valid && (timer_q >= MAX_TH);
  // An emergency on the green road pins it; one elsewhere cuts green at once.
  assign leave_green = emg_away || (!emg_here && (gap_out || max_out));

  // NOTE: every variable gets its default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    phase_d       = phase_q;
    cur_road_d    = cur_road_q;
    next_road_d   = next_road_q;
    timer_d       = (timer_q == T_SAT) ? timer_q : timer_q + TW'(1);
    green_start_d = 1'b0;
    unique case (phase_q)
      PH_GREEN: begin
        if (leave_green) begin
          phase_d     = PH_YELLOW;
          timer_d     = '0;
          next_road_d = emg_req ? emg_road : pick_road;
        end
      end
      PH_YELLOW: begin
        if (emg_req) next_road_d = emg_road;
        if (timer_q == YEL_TH) begin
          phase_d = PH_ALLRED;
          timer_d = '0;
        end
      end
      PH_ALLRED: begin
        if (emg_req) next_road_d = emg_road;
        if (timer_q == AR_TH) begin
          phase_d       = PH_GREEN;
          cur_road_d    = next_road_d;
          timer_d       = '0;
          green_start_d = 1'b1;
        end
      end
      default: begin
        phase_d = PH_GREEN;
        timer_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= PH_GREEN;
      cur_road_q    <= RW'(HOME_ROAD);
      next_road_q   <= RW'(HOME_ROAD);
      timer_q       <= '0;
      green_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      cur_road_q    <= cur_road_d;
      next_road_q   <= next_road_d;
      timer_q       <= timer_d;
      green_start_q <= green_start_d;
    end
  end

  // Lamps decode only registered state, so car_req never reaches them
  // combinationally.
  always_comb begin
    lights = '0;
    for (int i = 0; i < N_ROADS; i++) begin
      if (RW'(i) == cur_road_q) begin
        if (phase_q == PH_GREEN)       lights[2*i +: 2] = GREEN;
        else if (phase_q == PH_YELLOW) lights[2*i +: 2] = YELLOW;
      end
    end
  end

  assign cur_road    = cur_road_q;
  assign green_start = green_start_q;
  assign phase       = phase_q;

endmodule
